// File: rtl/word_serializer_pkg.sv
// Shared types for the word serializer and the downstream deserializer.
// State encodings are fixed so both ends decode the same values.
package word_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } ser_state_e;

    localparam int unsigned GAP_CNT_W = 4;
    localparam int unsigned GAP_MAX   = 15;

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial front end for shift_reg: valid/ready word intake,
// one bit per clock on ser_d/ser_en, optional inter-word gap and hold.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1,
    parameter int unsigned GAP       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             hold,
    output logic             ser_d,
    output logic             ser_en,
    output logic             frame_start,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST =
        (GAP > 0) ? GAP_CNT_W'(GAP - 1) : '0;
    localparam bit HAS_GAP = (GAP > 0);

    ser_state_e           state_q, state_d;
    logic [WIDTH-1:0]     sreg_q, sreg_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [GAP_CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic                 ser_d_q, ser_d_d;
    logic                 ser_en_q, ser_en_d;
    logic                 frame_q, frame_d;
    logic                 busy_q, busy_d;

    logic             cur_bit;
    logic [WIDTH-1:0] sreg_shift;
    logic             last_bit;
    logic             gap_last;
    logic             ready_raw;
    logic             accept;

    always_comb begin
        if (LSB_FIRST) begin
            cur_bit    = sreg_q[0];
            sreg_shift = {1'b0, sreg_q[WIDTH-1:1]};
        end else begin
            cur_bit    = sreg_q[WIDTH-1];
            sreg_shift = {sreg_q[WIDTH-2:0], 1'b0};
        end
    end

    assign last_bit = (bit_cnt_q == LAST_BIT);
    assign gap_last = (gap_cnt_q == GAP_LAST);

    // The terminal gap cycle also takes the next word, keeping the
    // word period at WIDTH+GAP with busy continuously high.
    always_comb begin
        ready_raw = 1'b0;
        unique case (state_q)
            ST_IDLE:  ready_raw = 1'b1;
            ST_SHIFT: ready_raw = !HAS_GAP && last_bit && !hold;
            ST_GAP:   ready_raw = gap_last;
            default:  ready_raw = 1'b0;
        endcase
    end

    assign in_ready = ready_raw & ~rst;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        ser_d_d   = ser_d_q;
        ser_en_d  = 1'b0;
        frame_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sreg_d    = in_data;
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!hold) begin
                    ser_d_d   = cur_bit;
                    ser_en_d  = 1'b1;
                    frame_d   = (bit_cnt_q == '0);
                    sreg_d    = sreg_shift;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (last_bit) begin
                        bit_cnt_d = '0;
                        if (HAS_GAP) begin
                            gap_cnt_d = '0;
                            state_d   = ST_GAP;
                        end else if (accept) begin
                            sreg_d = in_data;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_last) begin
                    gap_cnt_d = '0;
                    if (accept) begin
                        sreg_d    = in_data;
                        bit_cnt_d = '0;
                        state_d   = ST_SHIFT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sreg_q    <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            ser_d_q   <= 1'b0;
            ser_en_q  <= 1'b0;
            frame_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            ser_d_q   <= ser_d_d;
            ser_en_q  <= ser_en_d;
            frame_q   <= frame_d;
            busy_q    <= busy_d;
        end
    end

    assign ser_d       = ser_d_q;
    assign ser_en      = ser_en_q;
    assign frame_start = frame_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: three instances cover GAP=0,
// GAP=2 and MSB-first ordering.
module tb_word_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] data0 = '0, data2 = '0, datam = '0;
    logic v0 = 1'b0, v2 = 1'b0, vm = 1'b0;
    logic hold0 = 1'b0, hold2 = 1'b0, holdm = 1'b0;
    logic rdy0, rdy2, rdym;
    logic sd0, sd2, sdm;
    logic en0, en2, enm;
    logic fs0, fs2, fsm;
    logic busy0, busy2, busym;

    int checks = 0;
    int errors = 0;

    word_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .GAP(0)) u0 (
        .clk(clk), .rst(rst), .in_data(data0), .in_valid(v0),
        .in_ready(rdy0), .hold(hold0), .ser_d(sd0), .ser_en(en0),
        .frame_start(fs0), .busy(busy0)
    );

    word_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .GAP(2)) u2 (
        .clk(clk), .rst(rst), .in_data(data2), .in_valid(v2),
        .in_ready(rdy2), .hold(hold2), .ser_d(sd2), .ser_en(en2),
        .frame_start(fs2), .busy(busy2)
    );

    word_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .GAP(0)) um (
        .clk(clk), .rst(rst), .in_data(datam), .in_valid(vm),
        .in_ready(rdym), .hold(holdm), .ser_d(sdm), .ser_en(enm),
        .frame_start(fsm), .busy(busym)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // One isolated word on u0; seq[i] is the i-th bit expected on ser_d.
    task automatic send0(input string tag, input logic [7:0] w,
                         input logic [7:0] seq);
        logic [7:0] got;
        got = '0;
        data0 = w;
        v0 = 1'b1;
        chk({tag, "_rdy"}, {15'd0, rdy0}, 16'd1);
        step();
        v0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk({tag, "_en"}, {15'd0, en0}, 16'd1);
            chk({tag, "_bit"}, {15'd0, sd0}, {15'd0, seq[i]});
            chk({tag, "_fs"}, {15'd0, fs0}, {15'd0, i == 0});
            got[i] = sd0;
        end
        chk({tag, "_word"}, {8'd0, got}, {8'd0, w});
        step();
        chk({tag, "_en_end"}, {15'd0, en0}, 16'd0);
        chk({tag, "_busy_end"}, {15'd0, busy0}, 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] got16;
        logic [7:0]  got8;
        logic [7:0]  seq8;
        int acc, bits, zeros, cyc;

        // Reset state
        #2;
        chk("rst_rdy0", {15'd0, rdy0}, 16'd0);
        chk("rst_rdy2", {15'd0, rdy2}, 16'd0);
        chk("rst_en0", {15'd0, en0}, 16'd0);
        chk("rst_sd0", {15'd0, sd0}, 16'd0);
        chk("rst_fs0", {15'd0, fs0}, 16'd0);
        chk("rst_busy0", {15'd0, busy0}, 16'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("idle_rdy0", {15'd0, rdy0}, 16'd1);
        hold0 = 1'b1;
        #1;
        chk("idle_hold_rdy", {15'd0, rdy0}, 16'd1);
        hold0 = 1'b0;
        step();

        // 1: single word 8'hAB, LSB first
        send0("t1", 8'hAB, 8'hAB);

        // 2: back-to-back AB, 5C with no gap
        got16 = '0;
        data0 = 8'hAB;
        v0 = 1'b1;
        step();
        data0 = 8'h5C;
        for (int i = 0; i < 16; i++) begin
            chk("t2_rdy", {15'd0, rdy0}, {15'd0, (i == 7) || (i == 15)});
            step();
            if (i == 7) v0 = 1'b0;
            chk("t2_en", {15'd0, en0}, 16'd1);
            chk("t2_fs", {15'd0, fs0}, {15'd0, (i == 0) || (i == 8)});
            got16[i] = sd0;
        end
        chk("t2_word0", {8'd0, got16[7:0]}, 16'h00AB);
        chk("t2_word1", {8'd0, got16[15:8]}, 16'h005C);
        step();
        chk("t2_en_end", {15'd0, en0}, 16'd0);

        // 3: GAP=2 instance, two words
        got16 = '0;
        acc = 0;
        bits = 0;
        zeros = 0;
        data2 = 8'hAB;
        v2 = 1'b1;
        for (int c = 0; c < 40 && bits < 16; c++) begin
            if (v2 && rdy2) acc++;
            step();
            if (acc == 1) data2 = 8'h5C;
            if (acc == 2) v2 = 1'b0;
            if (acc > 0) chk("t3_busy", {15'd0, busy2}, 16'd1);
            if (en2) begin
                got16[bits] = sd2;
                chk("t3_fs", {15'd0, fs2}, {15'd0, (bits == 0) || (bits == 8)});
                bits++;
            end else if (bits == 8) begin
                zeros++;
            end
        end
        chk("t3_bits", 16'(bits), 16'd16);
        chk("t3_gap", 16'(zeros), 16'd2);
        chk("t3_acc", 16'(acc), 16'd2);
        chk("t3_word0", {8'd0, got16[7:0]}, 16'h00AB);
        chk("t3_word1", {8'd0, got16[15:8]}, 16'h005C);
        step();
        step();
        step();
        chk("t3_idle_busy", {15'd0, busy2}, 16'd0);

        // 4: hold for 3 cycles after bit 3
        got8 = '0;
        cyc = 0;
        data0 = 8'hAB;
        v0 = 1'b1;
        step();
        v0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            cyc++;
            chk("t4_en_a", {15'd0, en0}, 16'd1);
            got8[i] = sd0;
        end
        hold0 = 1'b1;
        for (int h = 0; h < 3; h++) begin
            #1;
            chk("t4_hold_rdy", {15'd0, rdy0}, 16'd0);
            step();
            cyc++;
            chk("t4_hold_en", {15'd0, en0}, 16'd0);
            chk("t4_hold_sd", {15'd0, sd0}, 16'd1);
            chk("t4_hold_fs", {15'd0, fs0}, 16'd0);
        end
        hold0 = 1'b0;
        for (int i = 4; i < 8; i++) begin
            step();
            cyc++;
            chk("t4_en_b", {15'd0, en0}, 16'd1);
            chk("t4_fs_b", {15'd0, fs0}, 16'd0);
            got8[i] = sd0;
        end
        chk("t4_cycles", 16'(cyc), 16'd11);
        chk("t4_word", {8'd0, got8}, 16'h00AB);
        step();

        // 5: async reset after bit 5, then a clean 8'h5C
        data0 = 8'hAB;
        v0 = 1'b1;
        step();
        v0 = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("t5_pre_sd", {15'd0, sd0}, 16'd1);
        rst = 1'b1;
        #1;
        chk("t5_en", {15'd0, en0}, 16'd0);
        chk("t5_sd", {15'd0, sd0}, 16'd0);
        chk("t5_fs", {15'd0, fs0}, 16'd0);
        chk("t5_busy", {15'd0, busy0}, 16'd0);
        chk("t5_rdy", {15'd0, rdy0}, 16'd0);
        step();
        rst = 1'b0;
        #1;
        send0("t5_next", 8'h5C, 8'h5C);

        // 6: MSB first, 8'hAB -> 1,0,1,0,1,0,1,1
        seq8 = '0;
        got8 = '0;
        datam = 8'hAB;
        vm = 1'b1;
        step();
        vm = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t6_en", {15'd0, enm}, 16'd1);
            chk("t6_fs", {15'd0, fsm}, {15'd0, i == 0});
            seq8[i] = sdm;
            got8 = {got8[6:0], sdm};
        end
        chk("t6_seq", {8'd0, seq8}, 16'h00D5);
        chk("t6_word", {8'd0, got8}, 16'h00AB);
        step();
        chk("t6_en_end", {15'd0, enm}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
